// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM block transfer sequencer with base writeback
module ldm_stm_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] IR,
    input  logic [31:0] BASE,
    input  logic [31:0] OFFSET,
    input  logic        MEM_DONE,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RW,
    output logic [3:0]  REG_NUM,
    output logic        REG_WE,
    output logic        WB_EN,
    output logic [31:0] WB_VALUE,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] remaining_q;
    logic [31:0] addr_q;
    logic [31:0] wb_value_q;
    logic        load_q;
    logic        wb_go_q;

    logic [15:0] list_in;
    logic        p_bit;
    logic        u_bit;
    logic [31:0] start_addr_d;
    logic [31:0] wb_value_d;
    logic        wb_go_d;
    logic [15:0] remaining_d;
    logic [3:0]  low_idx;
    logic        in_xfer;
    logic        unused_ir;

    assign list_in   = IR[15:0];
    assign p_bit     = IR[24];
    assign u_bit     = IR[23];
    assign unused_ir = ^{IR[31:25], IR[22]};

    always_comb begin
        start_addr_d = BASE;
        case ({p_bit, u_bit})
            2'b01:   start_addr_d = BASE;
            2'b11:   start_addr_d = BASE + 32'd4;
            2'b00:   start_addr_d = BASE - OFFSET + 32'd4;
            default: start_addr_d = BASE - OFFSET;
        endcase
    end

    assign wb_value_d = u_bit ? (BASE + OFFSET) : (BASE - OFFSET);
    // A load that overwrites the base register takes priority over writeback.
    assign wb_go_d    = IR[21] & ~(IR[20] & list_in[IR[19:16]]);

    assign remaining_d = remaining_q & (remaining_q - 16'd1);

    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (remaining_q[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            remaining_q <= 16'd0;
            addr_q      <= 32'd0;
            wb_value_q  <= 32'd0;
            load_q      <= 1'b0;
            wb_go_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        remaining_q <= list_in;
                        addr_q      <= start_addr_d;
                        wb_value_q  <= wb_value_d;
                        load_q      <= IR[20];
                        wb_go_q     <= wb_go_d;
                        state_q     <= (list_in != 16'd0) ? ST_XFER : ST_FIN;
                    end
                end
                ST_XFER: begin
                    if (MEM_DONE) begin
                        remaining_q <= remaining_d;
                        addr_q      <= addr_q + 32'd4;
                        if (remaining_d == 16'd0) begin
                            state_q <= wb_go_q ? ST_WB : ST_FIN;
                        end
                    end
                end
                ST_WB:   state_q <= ST_FIN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_xfer  = (state_q == ST_XFER);
    assign MEM_REQ  = in_xfer;
    assign MEM_ADDR = in_xfer ? addr_q : 32'd0;
    assign MEM_RW   = in_xfer & load_q;
    assign REG_NUM  = in_xfer ? low_idx : 4'd0;
    assign REG_WE   = in_xfer & MEM_DONE & load_q;
    assign WB_EN    = (state_q == ST_WB);
    assign WB_VALUE = WB_EN ? wb_value_q : 32'd0;
    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = (state_q == ST_FIN);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - randomized self-checking bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [31:0] IR = 32'd0;
    logic [31:0] BASE = 32'd0;
    logic [31:0] OFFSET = 32'd0;
    logic        MEM_DONE = 1'b0;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_RW;
    logic [3:0]  REG_NUM;
    logic        REG_WE;
    logic        WB_EN;
    logic [31:0] WB_VALUE;
    logic        BUSY;
    logic        DONE;

    int total = 0;
    int bad = 0;

    ldm_stm_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .BASE(BASE),
        .OFFSET(OFFSET), .MEM_DONE(MEM_DONE), .MEM_REQ(MEM_REQ),
        .MEM_ADDR(MEM_ADDR), .MEM_RW(MEM_RW), .REG_NUM(REG_NUM),
        .REG_WE(REG_WE), .WB_EN(WB_EN), .WB_VALUE(WB_VALUE),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_ir(input bit p, input bit u, input bit w, input bit l,
                                          input logic [3:0] rn, input logic [15:0] list);
        logic [31:0] v;
        v = 32'd0;
        v[24] = p;
        v[23] = u;
        v[21] = w;
        v[20] = l;
        v[19:16] = rn;
        v[15:0] = list;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, MEM_REQ, 0);
        chk({tag, "_addr"}, MEM_ADDR, 0);
        chk({tag, "_rw"}, MEM_RW, 0);
        chk({tag, "_reg"}, REG_NUM, 0);
        chk({tag, "_we"}, REG_WE, 0);
        chk({tag, "_wben"}, WB_EN, 0);
        chk({tag, "_wbval"}, WB_VALUE, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
    endtask

    // stall < 0 picks a random 0..2 wait per transfer; noise pulses START while busy.
    task automatic run_op(input logic [31:0] ir, input logic [31:0] base, input logic [31:0] off,
                          input int stall, input bit noise);
        logic [31:0] exp_addr[$];
        int          exp_reg[$];
        logic [15:0] list;
        logic [31:0] start_addr;
        logic [31:0] wbv;
        bit          l;
        bit          wb_exp;
        int          ns;
        list = ir[15:0];
        l = ir[20];
        if (ir[23]) start_addr = ir[24] ? base + 4 : base;
        else        start_addr = ir[24] ? base - off : base - off + 4;
        for (int r = 0; r < 16; r++) begin
            if (list[r]) begin
                exp_addr.push_back(start_addr + 32'(4 * exp_reg.size()));
                exp_reg.push_back(r);
            end
        end
        wbv = ir[23] ? base + off : base - off;
        wb_exp = (list != 0) && ir[21] && !(l && list[ir[19:16]]);

        @(negedge CLK);
        START = 1'b1; IR = ir; BASE = base; OFFSET = off; MEM_DONE = 1'($urandom);
        #1 chk("start_busy", BUSY, 0);
        @(negedge CLK);
        START = 1'b0; IR = $urandom; BASE = $urandom; OFFSET = $urandom;
        for (int j = 0; j < exp_reg.size(); j++) begin
            ns = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int s = 0; s <= ns; s++) begin
                MEM_DONE = (s == ns);
                START = noise & 1'($urandom);
                #1;
                chk("xfer_req", MEM_REQ, 1);
                chk("xfer_addr", MEM_ADDR, exp_addr[j]);
                chk("xfer_reg", REG_NUM, exp_reg[j]);
                chk("xfer_rw", MEM_RW, l);
                chk("xfer_we", REG_WE, (s == ns) && l);
                chk("xfer_busy", BUSY, 1);
                @(negedge CLK);
            end
        end
        START = 1'b0;
        MEM_DONE = 1'($urandom);
        if (wb_exp) begin
            #1;
            chk("wb_en", WB_EN, 1);
            chk("wb_value", WB_VALUE, wbv);
            chk("wb_req", MEM_REQ, 0);
            chk("wb_we", REG_WE, 0);
            chk("wb_done", DONE, 0);
            @(negedge CLK);
            MEM_DONE = 1'($urandom);
        end
        #1;
        chk("fin_done", DONE, 1);
        chk("fin_wben", WB_EN, 0);
        chk("fin_req", MEM_REQ, 0);
        chk("fin_we", REG_WE, 0);
        chk("fin_busy", BUSY, 1);
        @(negedge CLK);
        MEM_DONE = 1'b0;
        #1;
        chk("idle_done", DONE, 0);
        chk("idle_busy", BUSY, 0);
    endtask

    initial begin
        logic [31:0] ir;
        repeat (2) @(negedge CLK);
        #1 chk_all_zero("reset");
        @(negedge CLK);
        RESET = 1'b1;

        run_op(mk_ir(0, 1, 1, 1, 4'd2, 16'h0029), 32'h100, 32'd12, 0, 0);
        run_op(mk_ir(1, 0, 1, 0, 4'd13, 16'h40F0), 32'h1000, 32'd20, 0, 0);
        run_op(mk_ir(1, 1, 0, 1, 4'd0, 16'h0006), 32'h2000, 32'd8, 3, 0);
        run_op(mk_ir(0, 0, 1, 1, 4'd3, 16'h0007), 32'h4, 32'd12, 0, 0);
        run_op(mk_ir(0, 1, 1, 1, 4'd5, 16'h0000), 32'h300, 32'd0, 0, 0);
        run_op(mk_ir(0, 1, 1, 1, 4'd1, 16'h0006), 32'h500, 32'd8, 0, 0);
        run_op(mk_ir(0, 1, 1, 0, 4'd1, 16'h0006), 32'h500, 32'd8, 1, 0);
        run_op(mk_ir(1, 1, 1, 1, 4'd9, 16'h8001), 32'hFFFFFFF8, 32'd8, -1, 1);

        for (int n = 0; n < 40; n++) begin
            ir = $urandom;
            if (n % 8 == 0) ir[15:0] = 16'd0;
            run_op(ir, $urandom, 32'(4 * $countones(ir[15:0])), -1, 1'($urandom));
        end

        @(negedge CLK);
        START = 1'b1; IR = mk_ir(0, 1, 1, 0, 4'd4, 16'h000F); BASE = 32'h800; OFFSET = 32'd16;
        @(negedge CLK);
        START = 1'b0; MEM_DONE = 1'b1;
        #1 chk("rst_first_addr", MEM_ADDR, 32'h800);
        @(negedge CLK);
        MEM_DONE = 1'b0;
        #1 chk("rst_second_reg", REG_NUM, 1);
        RESET = 1'b0;
        @(negedge CLK);
        #1 chk_all_zero("midrst");
        RESET = 1'b1;
        run_op(mk_ir(0, 1, 1, 0, 4'd4, 16'h000F), 32'h800, 32'd16, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
